// File: rtl/gearbox_tx_sched.sv
// Cycle scheduler for the 32-bit PCS TX gearbox: 33-slot period with one idle slot,
// an early trdy drop that lines the source bubble up with that slot, and source-compliance monitoring.
module gearbox_tx_sched #(
  parameter int SEQ_LEN   = 33,
  parameter int TRDY_LEAD = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_rx_data_valid,
  input  logic                 i_clr_stats,
  output logic                 o_tx_trdy,
  output logic [5:0]           o_gb_slot,
  output logic                 o_gb_idle_slot,
  output logic                 o_gb_blk_first,
  output logic                 o_running,
  output logic                 o_overrun,
  output logic                 o_underrun,
  output logic [CNT_WIDTH-1:0] o_overrun_cnt,
  output logic [CNT_WIDTH-1:0] o_underrun_cnt
);

  localparam logic [5:0]           IDLE_SLOT = 6'(SEQ_LEN - 1);
  localparam logic [5:0]           TRDY_SLOT = 6'((SEQ_LEN - 1 - TRDY_LEAD) % SEQ_LEN);
  localparam logic [5:0]           WARM_LAST = 6'(TRDY_LEAD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [5:0]           slot_q, slot_d;
  logic [5:0]           slot_inc;
  logic                 trdy_q, trdy_d;
  logic                 idle_q, idle_d;
  logic                 first_q, first_d;
  logic                 running_q, running_d;
  logic                 ovr_q, ovr_d;
  logic                 unr_q, unr_d;
  logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [CNT_WIDTH-1:0] unr_cnt_q, unr_cnt_d;
  logic                 ovr_evt;
  logic                 unr_evt;

  assign slot_inc = (slot_q == IDLE_SLOT) ? 6'd0 : slot_q + 6'd1;

  // Warmup length equals the trdy lead, so RUN begins exactly when the first
  // trdy-driven valid reaches the gearbox input.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (!i_enable) begin
      state_d = ST_DISABLED;
      slot_d  = 6'd0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_WARMUP;
          slot_d  = 6'd0;
        end
        ST_WARMUP: begin
          slot_d = slot_inc;
          if (slot_q == WARM_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          slot_d = slot_inc;
        end
        default: begin
          state_d = ST_DISABLED;
          slot_d  = 6'd0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    running_d = (state_d != ST_DISABLED);
    trdy_d    = running_d && (slot_d != TRDY_SLOT);
    idle_d    = running_d && (slot_d == IDLE_SLOT);
    first_d   = running_d && (slot_d != IDLE_SLOT) && !slot_d[0];
  end

  assign ovr_evt = (state_q == ST_RUN) && idle_q && i_rx_data_valid;
  assign unr_evt = (state_q == ST_RUN) && !idle_q && !i_rx_data_valid;

  always_comb begin
    ovr_d     = ovr_q;
    unr_d     = unr_q;
    ovr_cnt_d = ovr_cnt_q;
    unr_cnt_d = unr_cnt_q;
    if (i_clr_stats) begin
      ovr_d     = 1'b0;
      unr_d     = 1'b0;
      ovr_cnt_d = '0;
      unr_cnt_d = '0;
    end else begin
      if (ovr_evt) begin
        ovr_d = 1'b1;
        if (ovr_cnt_q != CNT_MAX) begin
          ovr_cnt_d = ovr_cnt_q + CNT_WIDTH'(1);
        end
      end
      if (unr_evt) begin
        unr_d = 1'b1;
        if (unr_cnt_q != CNT_MAX) begin
          unr_cnt_d = unr_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_DISABLED;
      slot_q    <= 6'd0;
      trdy_q    <= 1'b0;
      idle_q    <= 1'b0;
      first_q   <= 1'b0;
      running_q <= 1'b0;
      ovr_q     <= 1'b0;
      unr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      unr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      trdy_q    <= trdy_d;
      idle_q    <= idle_d;
      first_q   <= first_d;
      running_q <= running_d;
      ovr_q     <= ovr_d;
      unr_q     <= unr_d;
      ovr_cnt_q <= ovr_cnt_d;
      unr_cnt_q <= unr_cnt_d;
    end
  end

  assign o_tx_trdy      = trdy_q;
  assign o_gb_slot      = slot_q;
  assign o_gb_idle_slot = idle_q;
  assign o_gb_blk_first = first_q;
  assign o_running      = running_q;
  assign o_overrun      = ovr_q;
  assign o_underrun     = unr_q;
  assign o_overrun_cnt  = ovr_cnt_q;
  assign o_underrun_cnt = unr_cnt_q;

endmodule
